// File: rtl/sms_mapper.sv
// Sega-style cartridge mapper: paging registers, CPU cycle decode, SDRAM req/ack sequencing
// with CPU wait-state generation and a single-entry read cache.
module sms_mapper #(
    parameter int                         SDRAM_ADDR_BITS = 24,
    parameter int                         ROM_PAGES_LOG2  = 5,
    parameter logic [SDRAM_ADDR_BITS-1:0] CART_RAM_BASE   = 24'h400000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_en,
    input  logic [15:0]                cpu_addr,
    input  logic [7:0]                 cpu_dout,
    input  logic                       n_mreq,
    input  logic                       n_rd,
    input  logic                       n_wr,
    input  logic [7:0]                 mem_ctrl,
    input  logic                       loader_wr,
    input  logic [7:0]                 bios_data,
    input  logic [7:0]                 ram_data,
    output logic                       ram_we,
    output logic [12:0]                ram_addr,
    output logic                       sdram_req,
    output logic                       sdram_we,
    output logic [SDRAM_ADDR_BITS-1:0] sdram_addr,
    output logic [7:0]                 sdram_wdata,
    input  logic                       sdram_ack,
    input  logic [7:0]                 sdram_rdata,
    output logic                       wait_n,
    output logic [7:0]                 mem_din,
    output logic                       dbg_state
);
    // SDRAM handshake: sdram_req rises with addr/we/wdata and all four stay stable until the
    // one-clk sdram_ack pulse; req drops on the clk after ack, read data is valid with ack.
    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    localparam logic [7:0] BANK_MASK = 8'((1 << ROM_PAGES_LOG2) - 1);

    state_t                     r_state;
    logic [7:0]                 r_ctrl, r_bank0, r_bank1, r_bank2;
    logic                       r_cyc_prev, r_done, r_req, r_we, r_ram_we, r_cache_valid;
    logic [SDRAM_ADDR_BITS-1:0] r_addr, r_cache_addr;
    logic [7:0]                 r_wdata, r_cache_data;

    logic                       w_rd_cyc, w_wr_cyc, w_new, w_is_ram, w_is_cram;
    logic                       w_cart_rd, w_cram_wr, w_hit, w_reg_wr, w_unused;
    logic [7:0]                 w_bank, w_bank_m;
    logic [SDRAM_ADDR_BITS-1:0] w_sd_addr;

    assign w_rd_cyc  = !n_mreq && !n_rd;
    assign w_wr_cyc  = !n_mreq && !n_wr;
    assign w_new     = cpu_en && (w_rd_cyc || w_wr_cyc) && !r_cyc_prev;
    assign w_is_ram  = (cpu_addr[15:14] == 2'b11);
    assign w_is_cram = (cpu_addr[15:14] == 2'b10) && r_ctrl[3];

    // The first 1KB always maps to ROM page 0 so the reset vectors survive bank switching.
    always_comb begin
        w_bank = r_bank2;
        if (cpu_addr[15:10] == 6'd0)
            w_bank = 8'd0;
        else if (cpu_addr[15:14] == 2'b00)
            w_bank = r_bank0;
        else if (cpu_addr[15:14] == 2'b01)
            w_bank = r_bank1;
    end

    assign w_bank_m  = w_bank & BANK_MASK;
    assign w_sd_addr = w_is_cram
                     ? CART_RAM_BASE + SDRAM_ADDR_BITS'({r_ctrl[2], cpu_addr[13:0]})
                     : SDRAM_ADDR_BITS'({w_bank_m, cpu_addr[13:0]});

    assign w_cart_rd = w_rd_cyc && !w_is_ram && mem_ctrl[3] && !mem_ctrl[6];
    assign w_cram_wr = w_wr_cyc && w_is_cram;
    assign w_hit     = r_cache_valid && (r_cache_addr == w_sd_addr);
    assign w_reg_wr  = w_new && w_wr_cyc && (cpu_addr[15:2] == 14'h3FFF);
    assign w_unused  = ^{mem_ctrl[7], mem_ctrl[5:4], mem_ctrl[2:0], r_ctrl[7:4], r_ctrl[1:0]};

    // r_done holds the CPU released once its SDRAM access has completed, even if a loader
    // write cleared the cache in the same clk; it clears when the bus cycle ends.
    assign wait_n = reset || !((w_cart_rd && !w_hit && !r_done) || (w_cram_wr && !r_done));

    always_comb begin
        mem_din = 8'hFF;
        if (w_rd_cyc) begin
            if (w_is_ram)
                mem_din = ram_data;
            else if (!mem_ctrl[3])
                mem_din = bios_data;
            else if (!mem_ctrl[6])
                mem_din = r_cache_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ctrl        <= 8'd0;
            r_bank0       <= 8'd0;
            r_bank1       <= 8'd1;
            r_bank2       <= 8'd2;
            r_cyc_prev    <= 1'b0;
            r_done        <= 1'b0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_ram_we      <= 1'b0;
            r_cache_valid <= 1'b0;
            r_addr        <= '0;
            r_cache_addr  <= '0;
            r_wdata       <= 8'd0;
            r_cache_data  <= 8'd0;
        end else begin
            r_ram_we <= w_new && w_wr_cyc && w_is_ram;
            if (cpu_en)
                r_cyc_prev <= w_rd_cyc || w_wr_cyc;
            if (!(w_rd_cyc || w_wr_cyc))
                r_done <= 1'b0;
            if (w_reg_wr) begin
                case (cpu_addr[1:0])
                    2'd0: r_ctrl  <= cpu_dout;
                    2'd1: r_bank0 <= cpu_dout;
                    2'd2: r_bank1 <= cpu_dout;
                    default: r_bank2 <= cpu_dout;
                endcase
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_new && ((w_cart_rd && !w_hit) || w_cram_wr)) begin
                        r_req   <= 1'b1;
                        r_we    <= w_wr_cyc;
                        r_addr  <= w_sd_addr;
                        r_wdata <= cpu_dout;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    if (sdram_ack) begin
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        if (!r_we) begin
                            r_cache_addr  <= r_addr;
                            r_cache_data  <= sdram_rdata;
                            r_cache_valid <= 1'b1;
                        end else if (r_cache_addr == r_addr) begin
                            r_cache_data <= r_wdata;
                        end
                    end
                end
            endcase
            // Invalidation is last so it overrides a fill in the same clk.
            if (loader_wr || w_reg_wr)
                r_cache_valid <= 1'b0;
        end
    end

    assign ram_we      = r_ram_we;
    assign ram_addr    = cpu_addr[12:0];
    assign sdram_req   = r_req;
    assign sdram_we    = r_we;
    assign sdram_addr  = r_addr;
    assign sdram_wdata = r_wdata;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_sms_mapper.sv
// Bench for sms_mapper: table of CPU bus cycles plus hand-written loader-collision and
// reset-during-request sequences; an SDRAM responder checks requests against exp_q.
module tb_sms_mapper;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        n_mreq = 1'b1, n_rd = 1'b1, n_wr = 1'b1;
    logic [7:0]  mem_ctrl = 8'hFF;
    logic        loader_wr = 1'b0;
    logic [7:0]  bios_data, ram_data;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic        sdram_req, sdram_we;
    logic [23:0] sdram_addr;
    logic [7:0]  sdram_wdata;
    logic        sdram_ack = 1'b0;
    logic [7:0]  sdram_rdata = 8'h00;
    logic        wait_n;
    logic [7:0]  mem_din;
    logic        dbg_state;

    sms_mapper dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_mreq(n_mreq), .n_rd(n_rd), .n_wr(n_wr), .mem_ctrl(mem_ctrl), .loader_wr(loader_wr),
        .bios_data(bios_data), .ram_data(ram_data), .ram_we(ram_we), .ram_addr(ram_addr),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_wdata(sdram_wdata), .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata),
        .wait_n(wait_n), .mem_din(mem_din), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    assign bios_data = cpu_addr[7:0] ^ 8'h3C;
    assign ram_data  = cpu_addr[7:0] ^ 8'hC3;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  mctl;
        logic        req;
        logic [23:0] sa;
        logic [7:0]  rd;
        logic [7:0]  din;
        logic        stall;
        logic        rwe;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        sd_auto = 1'b1;
    logic [7:0]  sd_next = 8'h00;
    int          req_cnt = 0;
    int          ramwe_cnt = 0;
    logic [12:0] last_ram_addr = 13'd0;
    logic        prev_req = 1'b0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sdram_req && !prev_req)
            req_cnt <= req_cnt + 1;
        prev_req <= sdram_req;
        if (ram_we) begin
            ramwe_cnt     <= ramwe_cnt + 1;
            last_ram_addr <= ram_addr;
        end
    end

    // SDRAM responder: pops the expected request, then acks after a random latency.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (sd_auto && sdram_req && !reset) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: got addr %0h we %0b, none expected", sdram_addr, sdram_we);
                end else begin
                    e = exp_q.pop_front();
                    check("sdram_req", {sdram_we, sdram_addr, (sdram_we ? sdram_wdata : 8'h00)}, e);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                sdram_rdata = sd_next;
                sdram_ack   = 1'b1;
                @(negedge clk);
                sdram_ack   = 1'b0;
                @(negedge clk);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_cycle(input logic wr, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a;
        cpu_dout = d;
        n_mreq   = 1'b0;
        if (wr) n_wr = 1'b0;
        else    n_rd = 1'b0;
        cpu_en   = 1'b1;
        @(negedge clk);
        cpu_en   = 1'b0;
    endtask

    task automatic end_cycle();
        n_mreq = 1'b1;
        n_rd   = 1'b1;
        n_wr   = 1'b1;
        cpu_en = 1'b1;
        @(negedge clk);
        cpu_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_cycle(input vec_t v, output logic [7:0] din, output int waits);
        mem_ctrl = v.mctl;
        start_cycle(v.wr, v.a, v.d);
        waits = 0;
        while (wait_n !== 1'b1 && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 40) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout: wait_n still %b at addr %0h", wait_n, v.a);
        end
        din = mem_din;
        end_cycle();
    endtask

    task automatic add(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       input logic [7:0] mctl, input logic req, input logic [23:0] sa,
                       input logic [7:0] rd, input logic [7:0] din, input logic stall,
                       input logic rwe);
        vec_t v;
        v = '{wr, a, d, mctl, req, sa, rd, din, stall, rwe};
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         rc0, rw0, waits;
        logic [7:0] din;
        rc0 = req_cnt;
        rw0 = ramwe_cnt;
        if (v.req) begin
            exp_q.push_back({v.wr, v.sa, (v.wr ? v.d : 8'h00)});
            sd_next = v.rd;
        end
        bus_cycle(v, din, waits);
        check({tag, "_req_count"}, 33'(req_cnt - rc0), 33'(v.req));
        check({tag, "_stall"}, 33'(waits > 0), 33'(v.stall));
        if (!v.wr)
            check({tag, "_mem_din"}, 33'(din), 33'(v.din));
        check({tag, "_ram_we"}, 33'(ramwe_cnt - rw0), 33'(v.rwe));
        if (v.rwe)
            check({tag, "_ram_addr"}, 33'(last_ram_addr), 33'(v.a[12:0]));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] r1, r2, r3, r4, r5, r6;
        vec_t       v;
        int         n;

        r1 = 8'($urandom_range(0, 255));
        r2 = 8'($urandom_range(0, 255));
        r3 = 8'($urandom_range(0, 255));
        r4 = 8'($urandom_range(0, 255));
        r5 = 8'($urandom_range(0, 255));
        r6 = 8'($urandom_range(0, 255));

        //   wr  addr      data   mctl   req  sdram_addr   rdata  din    stall rwe
        add(0, 16'h0100, 8'h00, 8'hF7, 0, 24'h000000, 8'h00, 8'h3C, 0, 0);
        add(0, 16'h4005, 8'h00, 8'hAB, 1, 24'h004005, 8'h5A, 8'h5A, 1, 0);
        add(0, 16'h4005, 8'h00, 8'hAB, 0, 24'h000000, 8'h00, 8'h5A, 0, 0);
        add(1, 16'hFFFF, 8'h07, 8'hAB, 0, 24'h000000, 8'h00, 8'h00, 0, 1);
        add(0, 16'h4005, 8'h00, 8'hAB, 1, 24'h004005, r1,    r1,    1, 0);
        add(0, 16'h8010, 8'h00, 8'hAB, 1, 24'h01C010, r2,    r2,    1, 0);
        add(1, 16'hFFFC, 8'h0C, 8'hAB, 0, 24'h000000, 8'h00, 8'h00, 0, 1);
        add(1, 16'h8001, 8'hA5, 8'hAB, 1, 24'h404001, 8'h00, 8'h00, 1, 0);
        add(1, 16'h2000, 8'h11, 8'hAB, 0, 24'h000000, 8'h00, 8'h00, 0, 0);
        add(0, 16'h8001, 8'h00, 8'hAB, 1, 24'h404001, r3,    r3,    1, 0);
        add(1, 16'h8001, 8'h5C, 8'hAB, 1, 24'h404001, 8'h00, 8'h00, 1, 0);
        add(0, 16'h8001, 8'h00, 8'hAB, 0, 24'h000000, 8'h00, 8'h5C, 0, 0);
        add(1, 16'hFFFD, 8'h3F, 8'hAB, 0, 24'h000000, 8'h00, 8'h00, 0, 1);
        add(0, 16'h0400, 8'h00, 8'hAB, 1, 24'h07C400, r4,    r4,    1, 0);
        add(0, 16'h0200, 8'h00, 8'hAB, 1, 24'h000200, r5,    r5,    1, 0);
        add(0, 16'hC123, 8'h00, 8'hAB, 0, 24'h000000, 8'h00, 8'hE0, 0, 0);
        add(0, 16'h0100, 8'h00, 8'hFF, 0, 24'h000000, 8'h00, 8'hFF, 0, 0);
        add(0, 16'h0100, 8'h00, 8'hAB, 1, 24'h000100, r6,    r6,    1, 0);

        repeat (3) @(negedge clk);
        check("reset_req", 33'(sdram_req), 33'(0));
        check("reset_wait_n", 33'(wait_n), 33'(1));
        check("reset_outs", {ram_we, dbg_state, mem_din}, {1'b0, 1'b0, 8'hFF});
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {sdram_req, wait_n, ram_we, dbg_state, mem_din},
              {1'b0, 1'b1, 1'b0, 1'b0, 8'hFF});

        // Loader write coincides with the read ack: handshake completes, cache stays invalid.
        sd_auto  = 1'b0;
        mem_ctrl = 8'hAB;
        start_cycle(1'b0, 16'h4006, 8'h00);
        n = 0;
        while (!sdram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ld_req", {sdram_req, sdram_we, sdram_addr}, {1'b1, 1'b0, 24'h004006});
        check("ld_wait_low", 33'(wait_n), 33'(0));
        sdram_rdata = 8'h9C;
        sdram_ack   = 1'b1;
        loader_wr   = 1'b1;
        @(negedge clk);
        sdram_ack   = 1'b0;
        loader_wr   = 1'b0;
        check("ld_after_ack", {sdram_req, wait_n, dbg_state, mem_din}, {1'b0, 1'b1, 1'b0, 8'h9C});
        end_cycle();
        sd_auto = 1'b1;
        v = '{1'b0, 16'h4006, 8'h00, 8'hAB, 1'b1, 24'h004006, 8'h4E, 8'h4E, 1'b1, 1'b0};
        run_vec(v, "ld_reread");

        foreach (vecs[i])
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while a request is outstanding; the late ack must be ignored.
        sd_auto  = 1'b0;
        mem_ctrl = 8'hAB;
        start_cycle(1'b0, 16'h4007, 8'h00);
        check("rst_req_up", {sdram_req, sdram_addr}, {1'b1, 24'h004007});
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_req_drop", {sdram_req, wait_n, dbg_state}, {1'b0, 1'b1, 1'b0});
        @(negedge clk);
        n_mreq = 1'b1;
        n_rd   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sdram_rdata = 8'hE7;
        sdram_ack   = 1'b1;
        @(negedge clk);
        sdram_ack   = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", {sdram_req, dbg_state, wait_n}, {1'b0, 1'b0, 1'b1});
        sd_auto = 1'b1;
        v = '{1'b0, 16'h0400, 8'h00, 8'hAB, 1'b1, 24'h000400, 8'h21, 8'h21, 1'b1, 1'b0};
        run_vec(v, "rst_bank0");
        v = '{1'b0, 16'h4007, 8'h00, 8'hAB, 1'b1, 24'h004007, 8'h43, 8'h43, 1'b1, 1'b0};
        run_vec(v, "rst_bank1");
        v = '{1'b0, 16'h8000, 8'h00, 8'hAB, 1'b1, 24'h008000, 8'h65, 8'h65, 1'b1, 1'b0};
        run_vec(v, "rst_bank2");

        repeat (4) @(negedge clk);
        check("exp_q_empty", 33'(exp_q.size()), 33'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
